// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: address/count sizing
// and the status bundle layout used by downstream monitors.
package fifo_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

   // Status bundle, MSB first: {full, empty, almost_full, almost_empty, overflow, underflow}
   typedef logic [5:0] fifo_status_t;
   localparam int ST_FULL  = 5;
   localparam int ST_EMPTY = 4;
   localparam int ST_AFULL = 3;
   localparam int ST_AEMPT = 2;
   localparam int ST_OVF   = 1;
   localparam int ST_UNF   = 0;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, read either
// registered (1-cycle latency, enable-held) or asynchronous when FWFT=1.
module fifo_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter bit FWFT   = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [1<<ADDR_W];

   // Contents are deliberately not reset.
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   generate
      if (FWFT) begin : g_async
         logic unused_rd;
         assign unused_rd = rst_n ^ re;
         assign rdata = mem[raddr];
      end else begin : g_reg
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)  rdata <= '0;
            else if (re) rdata <= mem[raddr];
      end
   endgenerate

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, thresholds, sticky errors and flush.
// Define FIFO_FWFT_EN for first-word-fall-through; otherwise data_out has 1-cycle latency.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  rd,
   output logic [DATA_W-1:0]     data_out,
   input  logic                  flush,
   input  logic                  clr_err,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [clog2(DEPTH):0] count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int ADDR_W = clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
`ifdef FIFO_FWFT_EN
   localparam bit FWFT = 1'b1;
`else
   localparam bit FWFT = 1'b0;
`endif

   logic [ADDR_W:0]  wr_ptr, rd_ptr;
   logic             wr_acc, rd_acc, ovf_set, unf_set;
   logic [CNT_W-1:0] cnt_nxt;

   // flush swallows wr/rd in its cycle, so neither can raise an error there.
   always_comb begin
      rd_acc  = rd & ~empty & ~flush;
      wr_acc  = wr & (~full | rd_acc) & ~flush;
      ovf_set = wr & ~wr_acc & ~flush;
      unf_set = rd & empty & ~flush;
      cnt_nxt = count;
      if (flush)                 cnt_nxt = '0;
      else if (wr_acc & ~rd_acc) cnt_nxt = count + 1'b1;
      else if (rd_acc & ~wr_acc) cnt_nxt = count - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= (AF_LEVEL == 0);
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         end
         count        <= cnt_nxt;
         full         <= (cnt_nxt == CNT_W'(DEPTH));
         empty        <= (cnt_nxt == '0);
         almost_full  <= (cnt_nxt >= CNT_W'(AF_LEVEL));
         almost_empty <= (cnt_nxt <= CNT_W'(AE_LEVEL));
         // A new error in the same cycle as clr_err wins.
         overflow     <= ovf_set | (overflow & ~clr_err);
         underflow    <= unf_set | (underflow & ~clr_err);
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .FWFT   (FWFT)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (data_in),
      .re    (rd_acc),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (data_out)
   );

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param; DATA_W=16/DEPTH=16 when FIFO_FWFT_EN is defined.
module tb_fifo_sync_param;

`ifdef FIFO_FWFT_EN
   localparam int DATA_W = 16;
   localparam int DEPTH  = 16;
`else
   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
`endif
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic [DATA_W-1:0] data_out;
   logic              full, empty, almost_full, almost_empty, overflow, underflow;
   logic [CNT_W-1:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_sync_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd),
      .data_out(data_out), .flush(flush), .clr_err(clr_err), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic fill(input int base);
      for (int i = 0; i < DEPTH; i++) begin
         wr = 1'b1; data_in = DATA_W'(base + i);
         step();
      end
      wr = 1'b0;
   endtask

   // Returns the word popped by one accepted read, honouring the read latency of the build.
   task automatic pop(output logic [DATA_W-1:0] v);
      rd = 1'b1;
`ifdef FIFO_FWFT_EN
      v = data_out;
      step();
`else
      step();
      v = data_out;
`endif
      rd = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      step();
      rst_n = 1'b0;
      #1;
      n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_tests++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b%b want 11", empty, almost_empty); end
      n_tests++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b%b want 00", full, almost_full); end
      n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b want 00", overflow, underflow); end
`ifndef FIFO_FWFT_EN
      n_tests++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", data_out); end
`endif
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         wr = 1'b1; data_in = DATA_W'(i);
         step();
         n_tests++; if (count !== CNT_W'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
         n_tests++; if (full !== (i + 1 == DEPTH)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b", i, full); end
         n_tests++; if (almost_full !== (i + 1 >= DEPTH - 1)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b", i, almost_full); end
         n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
      end
      wr = 1'b0;
   endtask

   task automatic test_drain();
      logic [DATA_W-1:0] v;
      for (int i = 0; i < DEPTH; i++) begin
         pop(v);
         n_tests++; if (v !== DATA_W'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, v, i); end
         n_tests++; if (count !== CNT_W'(DEPTH - 1 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, DEPTH - 1 - i); end
         n_tests++; if (empty !== (i == DEPTH - 1)) begin n_fail++; $display("FAIL drain_empty[%0d]: got %b", i, empty); end
         n_tests++; if (almost_empty !== (DEPTH - 1 - i <= 1)) begin n_fail++; $display("FAIL drain_aempty[%0d]: got %b", i, almost_empty); end
      end
      step();
`ifndef FIFO_FWFT_EN
      n_tests++; if (data_out !== DATA_W'(DEPTH - 1)) begin n_fail++; $display("FAIL drain_hold: got %0h want %0h", data_out, DEPTH - 1); end
`endif
      n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL drain_err: got %b%b want 00", overflow, underflow); end
   endtask

   task automatic test_overflow();
      logic [DATA_W-1:0] v;
      do_reset();
      fill(0);
      wr = 1'b1; data_in = DATA_W'('hAA);
      step();
      wr = 1'b0;
      n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
      n_tests++; if (count !== CNT_W'(DEPTH) || full !== 1'b1) begin n_fail++; $display("FAIL ovf_count: got %0d/%b want %0d/1", count, full, DEPTH); end
      wr = 1'b1; clr_err = 1'b1;
      step();
      idle();
      n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_err_wins: got %b want 1", overflow); end
      clr_err = 1'b1;
      step();
      idle();
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         pop(v);
         n_tests++; if (v !== DATA_W'(i)) begin n_fail++; $display("FAIL ovf_data[%0d]: got %0h want %0h", i, v, i); end
      end
      n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %b want 1", empty); end
   endtask

   task automatic test_underflow();
      logic [DATA_W-1:0] v;
      do_reset();
      rd = 1'b1; wr = 1'b1; data_in = DATA_W'('h55);
      step();
      idle();
      n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set: got %b want 1", underflow); end
      n_tests++; if (count !== CNT_W'(1) || empty !== 1'b0) begin n_fail++; $display("FAIL unf_count: got %0d/%b want 1/0", count, empty); end
`ifndef FIFO_FWFT_EN
      n_tests++; if (data_out !== '0) begin n_fail++; $display("FAIL unf_no_read: got %0h want 0", data_out); end
`endif
      pop(v);
      n_tests++; if (v !== DATA_W'('h55)) begin n_fail++; $display("FAIL unf_data: got %0h want 55", v); end
      n_tests++; if (count !== '0 || underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky: got %0d/%b want 0/1", count, underflow); end
      clr_err = 1'b1;
      step();
      idle();
      n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clr: got %b want 0", underflow); end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] v;
      logic [DATA_W-1:0] exp;
      do_reset();
      fill(0);
      for (int k = 0; k < 20; k++) begin
         wr = 1'b1; data_in = DATA_W'('h99 + k);
         pop(v);
         exp = (k < DEPTH) ? DATA_W'(k) : DATA_W'('h99 + k - DEPTH);
         n_tests++; if (v !== exp) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h want %0h", k, v, exp); end
         n_tests++; if (count !== CNT_W'(DEPTH) || full !== 1'b1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d/%b", k, count, full); end
      end
      wr = 1'b0;
      n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b%b want 00", overflow, underflow); end
      for (int j = 0; j < DEPTH; j++) begin
         pop(v);
         exp = DATA_W'('h99 + 20 - DEPTH + j);
         n_tests++; if (v !== exp) begin n_fail++; $display("FAIL b2b_tail[%0d]: got %0h want %0h", j, v, exp); end
      end
      n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", empty); end
   endtask

   task automatic test_flush();
      logic [DATA_W-1:0] v;
      do_reset();
      rd = 1'b1;
      step();
      idle();
      for (int i = 1; i <= 6; i++) begin
         wr = 1'b1; data_in = DATA_W'(i);
         step();
      end
      wr = 1'b0;
      pop(v);
      n_tests++; if (v !== DATA_W'(1) || count !== CNT_W'(5)) begin n_fail++; $display("FAIL flush_pre: got %0h/%0d want 1/5", v, count); end
      flush = 1'b1; wr = 1'b1; rd = 1'b1; data_in = DATA_W'('hEE);
      step();
      idle();
      n_tests++; if (count !== '0 || empty !== 1'b1 || almost_empty !== 1'b1) begin n_fail++; $display("FAIL flush_cnt: got %0d/%b%b want 0/11", count, empty, almost_empty); end
      n_tests++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %b%b want 00", full, almost_full); end
      n_tests++; if (underflow !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %b%b want 01", overflow, underflow); end
`ifndef FIFO_FWFT_EN
      n_tests++; if (data_out !== DATA_W'(1)) begin n_fail++; $display("FAIL flush_hold: got %0h want 1", data_out); end
`endif
      wr = 1'b1; data_in = DATA_W'('h3C);
      step();
      wr = 1'b0;
      pop(v);
      n_tests++; if (v !== DATA_W'('h3C) || count !== '0) begin n_fail++; $display("FAIL flush_post: got %0h/%0d want 3c/0", v, count); end
   endtask

   task automatic test_reset_mid();
      logic [DATA_W-1:0] v;
      do_reset();
      fill(0);
      wr = 1'b1; data_in = DATA_W'('hAA);
      step();
      rd = 1'b1; wr = 1'b1; data_in = DATA_W'(7);
      step(); step();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rmid_cnt: got %0d/%b%b want 0/10", count, empty, full); end
      n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b%b want 00", overflow, underflow); end
`ifndef FIFO_FWFT_EN
      n_tests++; if (data_out !== '0) begin n_fail++; $display("FAIL rmid_data: got %0h want 0", data_out); end
`endif
      idle();
      step();
      rst_n = 1'b1;
      step();
      wr = 1'b1; data_in = DATA_W'('h42);
      step();
      wr = 1'b0;
      pop(v);
      n_tests++; if (v !== DATA_W'('h42) || empty !== 1'b1) begin n_fail++; $display("FAIL rmid_post: got %0h/%b want 42/1", v, empty); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
